// File: rtl/datapath_pkg.sv
// Shared definitions for the execution datapath: widths, function-select codes
// and status-flag bit positions.
package datapath_pkg;

   localparam int unsigned WIDTH      = 4;
   localparam int unsigned REG_ADDR_W = 2;
   localparam int unsigned NUM_FLAGS  = 4;

   localparam logic [3:0] FS_TRA   = 4'b0000;
   localparam logic [3:0] FS_INC   = 4'b0001;
   localparam logic [3:0] FS_ADD   = 4'b0010;
   localparam logic [3:0] FS_ADDC  = 4'b0011;
   localparam logic [3:0] FS_ADDNB = 4'b0100;
   localparam logic [3:0] FS_SUB   = 4'b0101;
   localparam logic [3:0] FS_DEC   = 4'b0110;
   localparam logic [3:0] FS_TRA1  = 4'b0111;
   localparam logic [3:0] FS_AND   = 4'b1000;
   localparam logic [3:0] FS_OR    = 4'b1001;
   localparam logic [3:0] FS_XOR   = 4'b1010;
   localparam logic [3:0] FS_NOT   = 4'b1011;
   localparam logic [3:0] FS_TRB   = 4'b1100;
   localparam logic [3:0] FS_SHR   = 4'b1101;
   localparam logic [3:0] FS_SHL   = 4'b1110;
   localparam logic [3:0] FS_ZERO  = 4'b1111;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/datapath_unit_register_file.sv
// Four-entry register file: two combinational read ports, one synchronous
// write port, asynchronous active-high clear.
module register_file #(
   parameter int unsigned WIDTH  = datapath_pkg::WIDTH,
   parameter int unsigned ADDR_W = datapath_pkg::REG_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wa_i,
   input  logic [WIDTH-1:0]  wd_i,
   input  logic [ADDR_W-1:0] ra_a_i,
   output logic [WIDTH-1:0]  rd_a_o,
   input  logic [ADDR_W-1:0] ra_b_i,
   output logic [WIDTH-1:0]  rd_b_o
);

   localparam int unsigned NREGS = 1 << ADDR_W;

   logic [WIDTH-1:0] regs_q [NREGS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd_a_o = regs_q[ra_a_i];
   assign rd_b_o = regs_q[ra_b_i];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, B-mux, function unit, data memory,
// D-mux and registered V/C/N/Z flags, all driven by the decoded control word.
module datapath_unit #(
   parameter int unsigned WIDTH     = datapath_pkg::WIDTH,
   parameter int unsigned MEM_DEPTH = 16
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [datapath_pkg::REG_ADDR_W-1:0] DA,
   input  logic [datapath_pkg::REG_ADDR_W-1:0] AA,
   input  logic [datapath_pkg::REG_ADDR_W-1:0] BA,
   input  logic                                muxB,
   input  logic [3:0]                          FS,
   input  logic                                muxD,
   input  logic                                RW,
   input  logic                                MW,
   input  logic [WIDTH-1:0]                    constant,
   output logic [WIDTH-1:0]                    aData,
   output logic [WIDTH-1:0]                    bData,
   output logic [WIDTH-1:0]                    fOut,
   output logic [WIDTH-1:0]                    dBus,
   output logic                                V,
   output logic                                C,
   output logic                                N,
   output logic                                Z
);

   import datapath_pkg::*;

   localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);

   logic [WIDTH-1:0]     a_bus;
   logic [WIDTH-1:0]     b_reg;
   logic [WIDTH-1:0]     b_bus;
   logic [WIDTH-1:0]     f_res;
   logic [WIDTH-1:0]     d_bus;
   logic [WIDTH-1:0]     mem_rdata;
   logic [MEM_AW-1:0]    mem_addr;
   logic [WIDTH-1:0]     mem_q [MEM_DEPTH];
   logic [WIDTH-1:0]     add_y;
   logic                 add_cin;
   logic [WIDTH:0]       sum;
   logic                 c_calc;
   logic                 v_calc;
   logic [NUM_FLAGS-1:0] flags_q;
   logic [NUM_FLAGS-1:0] flags_d;

   register_file #(
      .WIDTH  (WIDTH),
      .ADDR_W (REG_ADDR_W)
   ) u_regfile (
      .clk_i  (CLK),
      .rst_i  (RST),
      .we_i   (RW),
      .wa_i   (DA),
      .wd_i   (d_bus),
      .ra_a_i (AA),
      .rd_a_o (a_bus),
      .ra_b_i (BA),
      .rd_b_o (b_reg)
   );

   assign b_bus     = muxB ? constant : b_reg;
   assign mem_addr  = a_bus[MEM_AW-1:0];
   assign mem_rdata = mem_q[mem_addr];

   // Every arithmetic code is one add A + Y + cin with Y in {0, B, ~B, all-ones},
   // so C and V always describe the add actually performed.
   always_comb begin
      add_y   = '0;
      add_cin = 1'b0;
      case (FS)
         FS_TRA:   begin add_y = '0;     add_cin = 1'b0; end
         FS_INC:   begin add_y = '0;     add_cin = 1'b1; end
         FS_ADD:   begin add_y = b_bus;  add_cin = 1'b0; end
         FS_ADDC:  begin add_y = b_bus;  add_cin = 1'b1; end
         FS_ADDNB: begin add_y = ~b_bus; add_cin = 1'b0; end
         FS_SUB:   begin add_y = ~b_bus; add_cin = 1'b1; end
         FS_DEC:   begin add_y = '1;     add_cin = 1'b0; end
         FS_TRA1:  begin add_y = '1;     add_cin = 1'b1; end
         default:  begin add_y = '0;     add_cin = 1'b0; end
      endcase
      sum = {1'b0, a_bus} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
   end

   always_comb begin
      f_res  = sum[WIDTH-1:0];
      c_calc = 1'b0;
      v_calc = 1'b0;
      case (FS)
         FS_AND:  f_res = a_bus & b_bus;
         FS_OR:   f_res = a_bus | b_bus;
         FS_XOR:  f_res = a_bus ^ b_bus;
         FS_NOT:  f_res = ~a_bus;
         FS_TRB:  f_res = b_bus;
         FS_SHR:  f_res = b_bus >> 1;
         FS_SHL:  f_res = b_bus << 1;
         FS_ZERO: f_res = '0;
         default: begin
            f_res  = sum[WIDTH-1:0];
            c_calc = sum[WIDTH];
            v_calc = (a_bus[WIDTH-1] == add_y[WIDTH-1]) &&
                     (sum[WIDTH-1] != a_bus[WIDTH-1]);
         end
      endcase
   end

   assign d_bus = muxD ? mem_rdata : f_res;

   always_comb begin
      flags_d         = '0;
      flags_d[FLAG_V] = v_calc;
      flags_d[FLAG_C] = c_calc;
      flags_d[FLAG_N] = f_res[WIDTH-1];
      flags_d[FLAG_Z] = (f_res == '0);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         flags_q <= '0;
         for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (RW && !muxD) begin
            flags_q <= flags_d;
         end
         if (MW) begin
            mem_q[mem_addr] <= b_bus;
         end
      end
   end

   assign aData = a_bus;
   assign bData = b_bus;
   assign fOut  = f_res;
   assign dBus  = d_bus;
   assign V     = flags_q[FLAG_V];
   assign C     = flags_q[FLAG_C];
   assign N     = flags_q[FLAG_N];
   assign Z     = flags_q[FLAG_Z];

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed scenarios with literal expectations plus
// randomized control words checked every cycle against an arithmetic model.
module tb_datapath_unit;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] DA, AA, BA;
   logic       muxB, muxD, RW, MW;
   logic [3:0] FS, constant;
   logic [3:0] aData, bData, fOut, dBus;
   logic       V, C, N, Z;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   int mR [4];
   int mM [16];
   int mV, mC, mN, mZ;

   datapath_unit #(
      .WIDTH     (4),
      .MEM_DEPTH (16)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .DA       (DA),
      .AA       (AA),
      .BA       (BA),
      .muxB     (muxB),
      .FS       (FS),
      .muxD     (muxD),
      .RW       (RW),
      .MW       (MW),
      .constant (constant),
      .aData    (aData),
      .bData    (bData),
      .fOut     (fOut),
      .dBus     (dBus),
      .V        (V),
      .C        (C),
      .N        (N),
      .Z        (Z)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Function unit from the opcode table, using plain integer arithmetic.
   function automatic void alu(input int fs, input int a, input int b,
                               output int f, output int c, output int v);
      int y, cin, r, sa, sy, s;
      y = 0; cin = 0; c = 0; v = 0; f = 0;
      if (fs < 8) begin
         case (fs)
            0: begin y = 0;      cin = 0; end
            1: begin y = 0;      cin = 1; end
            2: begin y = b;      cin = 0; end
            3: begin y = b;      cin = 1; end
            4: begin y = 15 - b; cin = 0; end
            5: begin y = 15 - b; cin = 1; end
            6: begin y = 15;     cin = 0; end
            default: begin y = 15; cin = 1; end
         endcase
         r  = a + y + cin;
         f  = r % 16;
         c  = r / 16;
         sa = (a > 7) ? a - 16 : a;
         sy = (y > 7) ? y - 16 : y;
         s  = sa + sy + cin;
         v  = (s > 7 || s < -8) ? 1 : 0;
      end else begin
         case (fs)
            8:  f = a & b;
            9:  f = a | b;
            10: f = a ^ b;
            11: f = 15 - a;
            12: f = b;
            13: f = b / 2;
            14: f = (b * 2) % 16;
            default: f = 0;
         endcase
      end
   endfunction

   function automatic void expect_bus(output int a, output int b, output int f,
                                      output int d, output int v, output int c);
      a = mR[int'(AA)];
      b = muxB ? int'(constant) : mR[int'(BA)];
      alu(int'(FS), a, b, f, c, v);
      d = muxD ? mM[a] : f;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) mR[i] = 0;
      for (int i = 0; i < 16; i++) mM[i] = 0;
      mV = 0; mC = 0; mN = 0; mZ = 0;
   endtask

   always @(negedge CLK) begin
      int ea, eb, ef, ed, ev, ec;
      if (cmp_en) begin
         expect_bus(ea, eb, ef, ed, ev, ec);
         chk("aData", int'(aData), ea);
         chk("bData", int'(bData), eb);
         chk("fOut",  int'(fOut),  ef);
         chk("dBus",  int'(dBus),  ed);
         chk("V", int'(V), mV);
         chk("C", int'(C), mC);
         chk("N", int'(N), mN);
         chk("Z", int'(Z), mZ);
      end
   end

   task automatic apply(input int da, input int aa, input int ba, input int mb,
                        input int fs, input int md, input int rw, input int mw,
                        input int k);
      DA = 2'(da); AA = 2'(aa); BA = 2'(ba); muxB = 1'(mb);
      FS = 4'(fs); muxD = 1'(md); RW = 1'(rw); MW = 1'(mw); constant = 4'(k);
      #2;
   endtask

   task automatic commit();
      int ea, eb, ef, ed, ev, ec;
      @(posedge CLK);
      if (!RST) begin
         expect_bus(ea, eb, ef, ed, ev, ec);
         if (MW) mM[ea] = eb;
         if (RW) mR[int'(DA)] = ed;
         if (RW && !muxD) begin
            mV = ev; mC = ec; mN = (ef >= 8) ? 1 : 0; mZ = (ef == 0) ? 1 : 0;
         end
      end
      #1;
   endtask

   task automatic load(input int r, input int k);
      apply(r, 0, 0, 1, 12, 0, 1, 0, k);
      commit();
   endtask

   task automatic nop_read(input int aa);
      apply(0, aa, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      RST = 1'b1;
      DA = '0; AA = '0; BA = '0; muxB = 1'b0; FS = '0;
      muxD = 1'b0; RW = 1'b0; MW = 1'b0; constant = '0;
      clear_model();
      #2;
      chk("reset_aData", int'(aData), 0);
      chk("reset_fOut",  int'(fOut),  0);
      chk("reset_dBus",  int'(dBus),  0);
      chk("reset_flags", int'({V, C, N, Z}), 0);
      cmp_en = 1'b1;
      commit();
      commit();
      RST = 1'b0;

      // Asynchronous reset in the middle of a cycle.
      load(2, 5);
      apply(0, 0, 2, 0, 0, 0, 0, 1, 0);
      commit();
      load(3, 12);
      nop_read(2);
      chk("pre_rst_aData", int'(aData), 5);
      chk("pre_rst_N", int'(N), 1);
      #1;
      RST = 1'b1;
      clear_model();
      #2;
      chk("rst_aData", int'(aData), 0);
      chk("rst_flags", int'({V, C, N, Z}), 0);
      DA = 2'd1; RW = 1'b1; muxB = 1'b1; constant = 4'd9; FS = 4'd12; muxD = 1'b1; AA = 2'd0;
      #1;
      chk("rst_mem0", int'(dBus), 0);
      muxD = 1'b0;
      commit();
      RST = 1'b0;
      nop_read(1);
      chk("rst_edge_nowrite", int'(aData), 0);

      // Immediate add.
      load(1, 3);
      apply(2, 1, 0, 1, 2, 0, 1, 0, 3);
      chk("imm_fOut", int'(fOut), 6);
      commit();
      nop_read(2);
      chk("imm_R2", int'(aData), 6);
      chk("imm_flags", int'({V, C, N, Z}), 0);

      // Signed overflow, then unsigned wrap.
      load(1, 7);
      load(2, 1);
      apply(3, 1, 2, 0, 2, 0, 1, 0, 0);
      chk("ovf_fOut", int'(fOut), 8);
      commit();
      nop_read(3);
      chk("ovf_flags_VCNZ", int'({V, C, N, Z}), 4'b1010);
      load(1, 15);
      apply(3, 1, 2, 0, 2, 0, 1, 0, 0);
      chk("wrap_fOut", int'(fOut), 0);
      commit();
      nop_read(3);
      chk("wrap_flags_VCNZ", int'({V, C, N, Z}), 4'b0101);

      // Subtract equal operands.
      load(1, 9);
      load(2, 9);
      apply(3, 1, 2, 0, 5, 0, 1, 0, 0);
      chk("sub_fOut", int'(fOut), 0);
      commit();
      nop_read(3);
      chk("sub_flags_VCNZ", int'({V, C, N, Z}), 4'b0101);

      // Memory round trip; the load from memory must not touch the flags.
      load(3, 4);
      load(1, 10);
      apply(0, 3, 1, 0, 0, 0, 0, 1, 0);
      commit();
      apply(0, 3, 0, 0, 0, 1, 1, 0, 0);
      chk("mem_dBus", int'(dBus), 10);
      chk("mem_fOut", int'(fOut), 4);
      commit();
      nop_read(0);
      chk("mem_R0", int'(aData), 10);
      chk("mem_flags_hold", int'({V, C, N, Z}), 4'b0010);

      // Read-during-write on the same register, then the zero opcode.
      load(1, 2);
      apply(1, 1, 0, 0, 1, 0, 1, 0, 0);
      chk("hazard_aData_old", int'(aData), 2);
      chk("hazard_fOut", int'(fOut), 3);
      commit();
      apply(0, 1, 0, 0, 15, 0, 0, 0, 0);
      chk("hazard_R1_new", int'(aData), 3);
      chk("fs1111_fOut", int'(fOut), 0);
      commit();

      // Random control words, with occasional reset pulses.
      for (int n = 0; n < 800; n++) begin
         apply(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 15)));
         if ($urandom_range(0, 49) == 0) begin
            RST = 1'b1;
            clear_model();
            commit();
            RST = 1'b0;
         end else begin
            commit();
         end
      end

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_unit.md
# datapath_unit

Execution datapath driven by the control unit's decoded control word: 4×4-bit register file, constant/register B-mux, 4-bit function unit, 16×4-bit data memory, D-mux and a registered status-flag set. It is the consuming end of the control-word interface: it takes `DA`, `AA`, `BA`, `muxB`, `FS`, `muxD`, `RW`, `MW` and `constant`, and returns the A-bus value (`aData`) that the program counter uses for branch and jump decisions.

## Interface
Parameters:
- `WIDTH`, 4: data width of registers, buses and memory words
- `MEM_DEPTH`, 16: data-memory words; the address is the low `log2(MEM_DEPTH)` bits of the A bus

Ports:
- `CLK` in 1: sole clock; all state changes on its rising edge
- `RST` in 1: asynchronous, active-high reset
- `DA` in 2: destination register index
- `AA` in 2: A-bus source register index
- `BA` in 2: B-bus source register index
- `muxB` in 1: 0 selects register `BA` for the B bus, 1 selects `constant`
- `FS` in 4: function select
- `muxD` in 1: 0 selects the function-unit result for the D bus, 1 selects the memory read data
- `RW` in 1: register write enable
- `MW` in 1: memory write enable
- `constant` in 4: zero-filled immediate
- `aData` out 4: A bus, combinational
- `bData` out 4: B bus after `muxB`, combinational
- `fOut` out 4: function-unit result, combinational
- `dBus` out 4: D bus, combinational
- `V`, `C`, `N`, `Z` out 1 each: registered status flags

## Operation
- Register file:
  - R0–R3; two combinational read ports (A, B) and one write port.
  - On a rising edge with `RW`=1, `R[DA] <= dBus`.
- Data memory:
  - Combinational read at `aData`.
  - On a rising edge with `MW`=1, `M[aData] <= bData`.
- Function unit encoding (`FS`):
  - Arithmetic: 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A−B (A+~B+1); 0110 A−1; 0111 A.
  - Logic: 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A.
  - Shifts: 1100 B; 1101 B>>1 (0 fill); 1110 B<<1 (0 fill); 1111 yields 0.
- Arithmetic is computed 5 bits wide, then truncated to 4 bits (wrap-around).
  - `C` is bit 4 of the 5-bit result.
  - `V` is signed overflow of the add performed.
  - For non-arithmetic FS, computed `C` and `V` are 0.
- Computed `N` = `fOut[3]`; computed `Z` = (`fOut`==0).
- Flags load on a rising edge only when `RW`=1 and `muxD`=0; otherwise they hold.

## Timing
- Reads, the function unit, both muxes and the memory read are all combinational. Result latency is the same cycle, and it is committed at the next rising edge.
- Reset: `RST`=1 asynchronously clears R0–R3, all memory words and V/C/N/Z to 0. While `RST` is high, `aData`, `bData` (with `muxB`=0), `fOut` (FS=0000) and `dBus` therefore read 0.
- Releasing reset mid-instruction: no write happens on the edge during which `RST` is still high.
- Read during write:
  - A read of `R[DA]` in the writing cycle returns the old value; the new value is visible after the edge.
  - The same rule applies to memory at `M[aData]`.
- `RW` and `MW` asserted together:
  - Memory stores `bData`.
  - If `muxD`=1, the register receives the pre-edge memory contents.
- `DA` = `AA` = `BA` is legal, e.g. R1 <= R1+R1.
- A register write to R0 is permitted; R0 is not hardwired to 0.

## Structure
- Shared package `datapath_pkg`:
  - FS localparams (`FS_TRA` … `FS_SHL`), `WIDTH`, `REG_ADDR_W` = 2.
  - Flag bit positions.
- Sub-module `register_file` holds R0–R3 with async reset, two read ports and one write port.
- The function unit, muxes, memory and flag register stay in `datapath_unit`.

## Test plan
- Reset: assert `RST` mid-cycle after loading R2=5 → `aData` (AA=2) drops to 0 immediately, flags read 0, and M[any]=0.
- Immediate add:
  - Load R1 with `muxB`=1, `constant`=3, FS=1100, DA=1, RW=1.
  - Then FS=0010, AA=1, `muxB`=1, `constant`=3, DA=2.
  - Required: R2=6 after the edge, with N=0 Z=0 C=0 V=0.
- Overflow/wrap:
  - R1=7, R2=1, FS=0010 → `fOut`=8, N=1, V=1, C=0.
  - R1=15, R2=1 → `fOut`=0, Z=1, C=1, V=0.
- Subtract equal: R1=R2=9, FS=0101 → `fOut`=0, Z=1, C=1.
- Memory round trip:
  - AA=3 (R3=4), BA=1 (R1=10), MW=1 → M[4]=10.
  - Next cycle with `muxD`=1, RW=1, DA=0 → R0=10, and the flags hold their previous values.
- Same-cycle hazard: DA=AA=1 with R1=2, FS=0001, RW=1 → `aData`=2 during the cycle and R1=3 after the edge. Also check FS=1111 → `fOut`=0.
